// File: rtl/longdivider_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : longdivider_param
//  Description : Parametrised sequential restoring divider, one quotient bit
//                per clock, with divide-by-zero detection. Defining the macro
//                LONGDIV_SIGNED_EN builds the two's complement (truncating)
//                variant, which adds a sign-fix state after the core loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module longdivider_param #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             s,
  input  logic             LA,
  input  logic             EB,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Done,
  output logic             DivZero
);

  localparam int                 c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);

`ifdef LONGDIV_SIGNED_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2,
    S_FIX  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q;        // operand registers
  logic [WIDTH-1:0]   rem_q;           // working remainder
  logic [WIDTH-1:0]   shift_q;         // dividend shifts out, quotient shifts in
  logic [c_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   q_q, r_q;
  logic               done_q, dz_q;

  // Operand values as seen on this edge: a same-edge load wins over the register
  logic [WIDTH-1:0]   w_a_eff, w_b_eff;
  logic [WIDTH-1:0]   w_a_start;       // value seeded into the shift register
  logic [WIDTH-1:0]   w_div;           // divisor used by the iteration
  logic [WIDTH:0]     w_shift;         // {R, Ashift} shifted left, top WIDTH+1 bits
  logic               w_ge;
  logic [WIDTH-1:0]   rem_d, quo_d;

  assign w_a_eff = LA ? DataA : a_q;
  assign w_b_eff = EB ? DataB : b_q;

`ifdef LONGDIV_SIGNED_EN
  logic [WIDTH-1:0] bmag_q;
  logic             negq_q, negr_q;
  logic [WIDTH-1:0] w_b_mag, w_q_fix, w_r_fix;

  // Magnitudes feed the unsigned core; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned
  assign w_a_start = w_a_eff[WIDTH-1] ? -w_a_eff : w_a_eff;
  assign w_b_mag   = w_b_eff[WIDTH-1] ? -w_b_eff : w_b_eff;
  assign w_div     = bmag_q;
  assign w_q_fix   = negq_q ? -shift_q : shift_q;
  assign w_r_fix   = negr_q ? -rem_q   : rem_q;
`else
  assign w_a_start = w_a_eff;
  assign w_div     = b_q;
`endif

  // One restoring step; the compare is WIDTH+1 bits so large divisors cannot overflow
  always_comb begin
    w_shift = {rem_q, shift_q[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, w_div});
    // When w_ge holds the difference is below the divisor, so the low bits suffice
    rem_d   = w_ge ? (w_shift[WIDTH-1:0] - w_div) : w_shift[WIDTH-1:0];
    quo_d   = {shift_q[WIDTH-2:0], w_ge};
  end

  // Control FSM plus datapath registers and registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef LONGDIV_SIGNED_EN
      bmag_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (LA) a_q <= DataA;
          if (EB) b_q <= DataB;
          if (s) begin
            if (w_b_eff == '0) begin
              state_q <= S_DONE;
              q_q     <= '1;
              r_q     <= w_a_eff;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CALC;
              rem_q   <= '0;
              shift_q <= w_a_start;
              cnt_q   <= c_CNT_INIT;
              dz_q    <= 1'b0;
`ifdef LONGDIV_SIGNED_EN
              bmag_q  <= w_b_mag;
              negq_q  <= w_a_eff[WIDTH-1] ^ w_b_eff[WIDTH-1];
              negr_q  <= w_a_eff[WIDTH-1];
`endif
            end
          end
        end
        S_CALC: begin
          rem_q   <= rem_d;
          shift_q <= quo_d;
          cnt_q   <= cnt_q - c_CNT_W'(1);
          if (cnt_q == '0) begin
`ifdef LONGDIV_SIGNED_EN
            state_q <= S_FIX;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
            q_q     <= quo_d;
            r_q     <= rem_d;
`endif
          end
        end
`ifdef LONGDIV_SIGNED_EN
        S_FIX: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          q_q     <= w_q_fix;
          r_q     <= w_r_fix;
        end
`endif
        S_DONE: begin
          if (!s) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Q       = q_q;
  assign R       = r_q;
  assign Done    = done_q;
  assign DivZero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_longdivider_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_longdivider_param
//  Description : Self-checking bench for longdivider_param (8- and 16-bit
//                instances) against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_longdivider_param;

`ifdef LONGDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        s8, la8, eb8, done8, dz8;
  logic [7:0]  da8, db8, q8, r8;
  logic        s16, la16, eb16, done16, dz16;
  logic [15:0] da16, db16, q16, r16;

  int errors = 0;
  int checks = 0;

  longdivider_param #(.WIDTH(8)) u_dut8 (
    .Clock(clk), .Resetn(rstn), .s(s8), .LA(la8), .EB(eb8),
    .DataA(da8), .DataB(db8), .Q(q8), .R(r8), .Done(done8), .DivZero(dz8)
  );

  longdivider_param #(.WIDTH(16)) u_dut16 (
    .Clock(clk), .Resetn(rstn), .s(s16), .LA(la16), .EB(eb16),
    .DataA(da16), .DataB(db16), .Q(q16), .R(r16), .Done(done16), .DivZero(dz16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer division (truncating) on the operand values
  function automatic int model_div(input int a_raw, input int b_raw, input int w, input bit want_q);
    int a, b;
    a = a_raw;
    b = b_raw;
    if (SGN) begin
      if (a >= (1 << (w - 1))) a = a - (1 << w);
      if (b >= (1 << (w - 1))) b = b - (1 << w);
    end
    return want_q ? (a / b) : (a % b);
  endfunction

  // ---------------- reference model, 8-bit ----------------
  logic [7:0] ma8, mb8, pq8, pr8, m_q8, m_r8;
  logic       m_busy8, m_done8, m_dz8;
  int         m_wait8;
  wire  [7:0] na8 = la8 ? da8 : ma8;
  wire  [7:0] nb8 = eb8 ? db8 : mb8;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ma8 <= '0; mb8 <= '0; pq8 <= '0; pr8 <= '0; m_q8 <= '0; m_r8 <= '0;
      m_busy8 <= 1'b0; m_done8 <= 1'b0; m_dz8 <= 1'b0; m_wait8 <= 0;
    end else if (!m_busy8 && !m_done8) begin
      ma8 <= na8;
      mb8 <= nb8;
      if (s8) begin
        if (nb8 == 8'h00) begin
          m_done8 <= 1'b1; m_q8 <= 8'hFF; m_r8 <= na8; m_dz8 <= 1'b1;
        end else begin
          m_busy8 <= 1'b1;
          m_wait8 <= 8 + int'(SGN);
          pq8 <= 8'(model_div(int'(na8), int'(nb8), 8, 1'b1));
          pr8 <= 8'(model_div(int'(na8), int'(nb8), 8, 1'b0));
        end
      end
    end else if (m_busy8) begin
      if (m_wait8 == 1) begin
        m_busy8 <= 1'b0; m_done8 <= 1'b1; m_q8 <= pq8; m_r8 <= pr8; m_dz8 <= 1'b0;
      end else begin
        m_wait8 <= m_wait8 - 1;
      end
    end else if (!s8) begin
      m_done8 <= 1'b0;
    end
  end

  // ---------------- reference model, 16-bit ----------------
  logic [15:0] ma16, mb16, pq16, pr16, m_q16, m_r16;
  logic        m_busy16, m_done16, m_dz16;
  int          m_wait16;
  wire  [15:0] na16 = la16 ? da16 : ma16;
  wire  [15:0] nb16 = eb16 ? db16 : mb16;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ma16 <= '0; mb16 <= '0; pq16 <= '0; pr16 <= '0; m_q16 <= '0; m_r16 <= '0;
      m_busy16 <= 1'b0; m_done16 <= 1'b0; m_dz16 <= 1'b0; m_wait16 <= 0;
    end else if (!m_busy16 && !m_done16) begin
      ma16 <= na16;
      mb16 <= nb16;
      if (s16) begin
        if (nb16 == 16'h0000) begin
          m_done16 <= 1'b1; m_q16 <= 16'hFFFF; m_r16 <= na16; m_dz16 <= 1'b1;
        end else begin
          m_busy16 <= 1'b1;
          m_wait16 <= 16 + int'(SGN);
          pq16 <= 16'(model_div(int'(na16), int'(nb16), 16, 1'b1));
          pr16 <= 16'(model_div(int'(na16), int'(nb16), 16, 1'b0));
        end
      end
    end else if (m_busy16) begin
      if (m_wait16 == 1) begin
        m_busy16 <= 1'b0; m_done16 <= 1'b1; m_q16 <= pq16; m_r16 <= pr16; m_dz16 <= 1'b0;
      end else begin
        m_wait16 <= m_wait16 - 1;
      end
    end else if (!s16) begin
      m_done16 <= 1'b0;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (rstn) begin
      chk("cyc_done8", done8, m_done8);
      chk("cyc_done16", done16, m_done16);
      if (!m_busy8) begin
        chk("cyc_q8", q8, m_q8);
        chk("cyc_r8", r8, m_r8);
      end
      if (!m_busy16) begin
        chk("cyc_q16", q16, m_q16);
        chk("cyc_r16", r16, m_r16);
      end
      if (m_done8)  chk("cyc_dz8", dz8, m_dz8);
      if (m_done16) chk("cyc_dz16", dz16, m_dz16);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input logic edz, input int elat);
    int  edges;
    bit  got;
    edges = 0;
    got   = 1'b0;
    @(negedge clk);
    da8 = a; db8 = b; la8 = 1'b1; eb8 = 1'b1; s8 = 1'b1;
    while (!got && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      la8 = 1'b0; eb8 = 1'b0;
      da8 = 8'($urandom); db8 = 8'($urandom);
      if (done8) got = 1'b1;
    end
    chk("lat8", edges, elat);
    chk("q8", q8, eq);
    chk("r8", r8, er);
    chk("dz8", dz8, edz);
    repeat (2) @(negedge clk);
    s8 = 1'b0;
    @(posedge clk);
    #1;
    chk("done_fall8", done8, 1'b0);
    @(negedge clk);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                       input logic [15:0] er, input int elat);
    int  edges;
    bit  got;
    edges = 0;
    got   = 1'b0;
    @(negedge clk);
    da16 = a; db16 = b; la16 = 1'b1; eb16 = 1'b1; s16 = 1'b1;
    while (!got && edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
      if (done16) begin
        got = 1'b1;
      end else begin
        // Operand loads toggling mid-computation must be ignored
        la16 = (edges % 2 == 0); eb16 = (edges % 2 == 0);
        da16 = 16'($urandom); db16 = 16'($urandom);
      end
    end
    la16 = 1'b0; eb16 = 1'b0;
    chk("lat16", edges, elat);
    chk("q16", q16, eq);
    chk("r16", r16, er);
    chk("dz16", dz16, 1'b0);
    @(negedge clk);
    s16 = 1'b0;
    @(posedge clk);
    #1;
    chk("done_fall16", done16, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int lat8;
    lat8 = SGN ? 10 : 9;
    rstn = 1'b0;
    s8 = 1'b0; la8 = 1'b0; eb8 = 1'b0; da8 = '0; db8 = '0;
    s16 = 1'b0; la16 = 1'b0; eb16 = 1'b0; da16 = '0; db16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_q8", q8, 8'h00);
    chk("rst_r8", r8, 8'h00);
    chk("rst_done8", done8, 1'b0);
    chk("rst_dz8", dz8, 1'b0);
    chk("rst_q16", q16, 16'h0000);
    chk("rst_done16", done16, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

`ifdef LONGDIV_SIGNED_EN
    run8(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10);
    run8(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10);
    run8(8'h10, 8'h02, 8'h08, 8'h00, 1'b0, 10);
    run8(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 10);
    run8(8'h64, 8'h00, 8'hFF, 8'h64, 1'b1, 1);
    run16(16'hFFFF, 16'h0003, 16'h0000, 16'hFFFF, 18);
`else
    run8(8'h10, 8'h02, 8'h08, 8'h00, 1'b0, 9);
    run8(8'h07, 8'h09, 8'h00, 8'h07, 1'b0, 9);
    run8(8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 9);
    run8(8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9);
    run8(8'hC8, 8'h81, 8'h01, 8'h47, 1'b0, 9);
    run8(8'h64, 8'h00, 8'hFF, 8'h64, 1'b1, 1);
    run16(16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 17);
    run16(16'h8001, 16'h8000, 16'h0001, 16'h0001, 17);
`endif

    // Reset asserted just after edge 4 of an 8-bit divide
    @(negedge clk);
    da8 = 8'h10; db8 = 8'h02; la8 = 1'b1; eb8 = 1'b1; s8 = 1'b1;
    @(posedge clk);
    #1;
    la8 = 1'b0; eb8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_q8", q8, 8'h00);
    chk("abort_r8", r8, 8'h00);
    chk("abort_done8", done8, 1'b0);
    chk("abort_dz8", dz8, 1'b0);
    chk("abort_q16", q16, 16'h0000);
    @(negedge clk);
    s8 = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run8(8'h10, 8'h02, 8'h08, 8'h00, 1'b0, lat8);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
